nfc_req_queue: RTL and testbench

- Parametrised successor to the single-way NFC test request generator.
- Accepts host commands (opcode, LBA, length, target way) through a valid/ready port and rejects unsupported opcodes or out-of-range ways.
- Translates each accepted command into a 264-bit NFC request entry and buffers it in a FIFO.
- Issues entries one at a time to the addressed way, with an independent command-ID counter per way. Sits between the host/test front-end and the per-way NFC controllers.

---
 rtl/nfc_req_pkg.sv | 80 ++++++++
 rtl/nfc_req_fifo.sv | 55 +++++
 rtl/nfc_req_queue.sv | 121 ++++++++++++
 tb/tb_nfc_req_queue.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/nfc_req_pkg.sv
// Shared definitions for the NFC request queue: host opcodes, entry field offsets,
// and the host-command to NFC-entry translation.
package nfc_req_pkg;

    localparam int REQ_WIDTH = 264;

    localparam int OPC_LSB  = 0;
    localparam int CID_LSB  = 16;
    localparam int ADDR_LSB = 32;
    localparam int LEN_LSB  = 80;
    localparam int AUX_LSB  = 104;

    localparam logic [15:0] HOP_1080       = 16'h1080;
    localparam logic [15:0] HOP_1085       = 16'h1085;
    localparam logic [15:0] HOP_3000       = 16'h3000;
    localparam logic [15:0] HOP_3500       = 16'h3500;
    localparam logic [15:0] HOP_D060       = 16'hD060;
    localparam logic [15:0] HOP_RESET      = 16'h00FF;
    localparam logic [15:0] HOP_SET_TIMING = 16'h01EF;
    localparam logic [15:0] HOP_SET_NVDDR2 = 16'h02EF;
    localparam logic [15:0] HOP_READ_PARAM = 16'h00EC;
    localparam logic [15:0] HOP_GET_FEAT   = 16'h01EE;
    localparam logic [15:0] HOP_READ_ID20  = 16'h2090;
    localparam logic [15:0] HOP_READ_ID00  = 16'h0090;
    localparam logic [15:0] HOP_READ_UID   = 16'h00ED;

    typedef struct packed {
        logic                 supported;
        logic [REQ_WIDTH-1:0] entry;
    } xlate_t;

    function automatic logic [REQ_WIDTH-1:0] build_entry(
        input logic [15:0] opc,
        input logic [15:0] cid,
        input logic [47:0] addr,
        input logic [23:0] len,
        input logic [63:0] aux
    );
        return {96'h0, aux, len, addr, cid, opc};
    endfunction

    // CID is left zero; it is filled in when the entry is issued to its way.
    function automatic xlate_t translate(
        input logic [15:0] hop,
        input logic [47:0] lba,
        input logic [23:0] len,
        input logic [63:0] timing_aux,
        input logic [63:0] nvddr2_aux
    );
        xlate_t      r;
        logic [15:0] opc;
        logic [47:0] addr;
        logic [23:0] blen;
        logic [63:0] aux;
        r.supported = 1'b1;
        opc  = hop;
        addr = '0;
        blen = '0;
        aux  = '0;
        case (hop)
            HOP_1080, HOP_1085, HOP_3000, HOP_3500, HOP_D060: begin
                addr = lba;
                blen = len;
            end
            HOP_RESET, HOP_READ_ID00, HOP_READ_UID: ;
            HOP_SET_TIMING: begin opc = 16'h00EF; addr = 48'd1; aux = timing_aux; end
            HOP_SET_NVDDR2: begin opc = 16'h00EF; addr = 48'd2; aux = nvddr2_aux; end
            HOP_READ_PARAM: blen = 24'h100;
            HOP_GET_FEAT:   begin opc = 16'h00EE; addr = 48'd1; blen = 24'h100; end
            HOP_READ_ID20:  begin opc = 16'h0090; addr = 48'h20; end
            default: begin
                r.supported = 1'b0;
                opc = '0;
            end
        endcase
        r.entry = build_entry(opc, 16'h0, addr, blen, aux);
        return r;
    endfunction

endpackage

// File: rtl/nfc_req_fifo.sv
// Synchronous FIFO with registered occupancy count; pushes on full and pops on
// empty are ignored.
module nfc_req_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_push,
    input  logic [W-1:0]             i_data,
    input  logic                     i_pop,
    output logic [W-1:0]             o_data,
    output logic                     o_full,
    output logic                     o_empty,
    output logic [$clog2(DEPTH):0]   o_cnt
);
    localparam int AW    = $clog2(DEPTH);
    localparam int CNT_W = AW + 1;

    logic [W-1:0]     r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [CNT_W-1:0] r_cnt;
    logic             w_do_push;
    logic             w_do_pop;

    assign o_full    = (r_cnt == CNT_W'(DEPTH));
    assign o_empty   = (r_cnt == '0);
    assign w_do_push = i_push & ~o_full;
    assign w_do_pop  = i_pop & ~o_empty;
    assign o_data    = r_mem[r_rd_ptr];
    assign o_cnt     = r_cnt;

    always_ff @(posedge clk) begin
        if (w_do_push) r_mem[r_wr_ptr] <= i_data;
    end

    // Depth is a power of two, so pointers wrap by natural overflow.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_cnt    <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
            case ({w_do_push, w_do_pop})
                2'b10:   r_cnt <= r_cnt + CNT_W'(1);
                2'b01:   r_cnt <= r_cnt - CNT_W'(1);
                default: r_cnt <= r_cnt;
            endcase
        end
    end

endmodule

// File: rtl/nfc_req_queue.sv
// Host command queue: validates and translates commands, buffers NFC entries,
// and issues them in order to per-way controllers with per-way command IDs.
module nfc_req_queue
    import nfc_req_pkg::*;
#(
    parameter int          WAY_NUM    = 1,
    parameter int          WAY_W      = 4,
    parameter int          FIFO_DEPTH = 4,
    parameter logic [63:0] TIMING_AUX = 64'h24,
    parameter logic [63:0] NVDDR2_AUX = 64'h0000_0000_0000_0007
) (
    input  logic                          clk,
    input  logic                          rst,
    output logic                          o_ready,
    input  logic                          i_valid,
    input  logic [15:0]                   i_opc,
    input  logic [47:0]                   i_lba,
    input  logic [23:0]                   i_len,
    input  logic [WAY_W-1:0]              i_way,
    output logic                          o_err,
    output logic [WAY_NUM-1:0]            o_req_valid,
    input  logic [WAY_NUM-1:0]            i_req_ready,
    output logic [REQ_WIDTH-1:0]          o_req_data,
    output logic [WAY_W-1:0]              o_req_way,
    output logic [$clog2(FIFO_DEPTH):0]   o_fifo_cnt
);
    localparam int FW = REQ_WIDTH + WAY_W;

    xlate_t                 w_xl;
    logic                   w_way_ok;
    logic                   w_accept;
    logic                   w_push;
    logic                   w_full;
    logic                   w_empty;
    logic                   w_pop;
    logic                   w_free;
    logic                   w_hs;
    logic [FW-1:0]          w_head;
    logic [WAY_W-1:0]       w_head_way;
    logic [WAY_NUM-1:0]     w_head_onehot;
    logic [15:0]            w_cid_new;
    logic [REQ_WIDTH-1:0]   w_load_data;

    logic [WAY_NUM-1:0]     r_req_valid;
    logic [REQ_WIDTH-1:0]   r_req_data;
    logic [WAY_W-1:0]       r_req_way;
    logic                   r_err;
    logic [15:0]            r_cid [WAY_NUM];

    assign w_xl     = translate(i_opc, i_lba, i_len, TIMING_AUX, NVDDR2_AUX);
    assign w_way_ok = ({{(32-WAY_W){1'b0}}, i_way} < 32'(WAY_NUM));
    assign w_accept = i_valid & ~w_full;
    assign w_push   = w_accept & w_xl.supported & w_way_ok;

    // The output register is reusable in the same cycle its request handshakes.
    assign w_hs   = |(r_req_valid & i_req_ready);
    assign w_free = (r_req_valid == '0) | w_hs;
    assign w_pop  = w_free & ~w_empty;

    nfc_req_fifo #(
        .W     (FW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_push),
        .i_data  ({i_way, w_xl.entry}),
        .i_pop   (w_pop),
        .o_data  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_cnt   (o_fifo_cnt)
    );

    assign w_head_way = w_head[FW-1 -: WAY_W];

    // A back-to-back request to the same way must see the post-handshake CID.
    always_comb begin
        w_cid_new     = '0;
        w_head_onehot = '0;
        for (int w = 0; w < WAY_NUM; w++) begin
            if (w_head_way == WAY_W'(w)) begin
                w_head_onehot[w] = 1'b1;
                w_cid_new = r_cid[w] + ((w_hs && r_req_way == WAY_W'(w)) ? 16'd1 : 16'd0);
            end
        end
        w_load_data = w_head[REQ_WIDTH-1:0];
        w_load_data[CID_LSB +: 16] = w_cid_new;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_req_valid <= '0;
            r_req_data  <= '0;
            r_req_way   <= '0;
            r_err       <= 1'b0;
            for (int w = 0; w < WAY_NUM; w++) r_cid[w] <= '0;
        end else begin
            r_err <= w_accept & ~(w_xl.supported & w_way_ok);
            for (int w = 0; w < WAY_NUM; w++) begin
                if (w_hs && r_req_way == WAY_W'(w)) r_cid[w] <= r_cid[w] + 16'd1;
            end
            if (w_free) begin
                if (w_pop) begin
                    r_req_valid <= w_head_onehot;
                    r_req_data  <= w_load_data;
                    r_req_way   <= w_head_way;
                end else begin
                    r_req_valid <= '0;
                end
            end
        end
    end

    assign o_ready     = ~w_full;
    assign o_err       = r_err;
    assign o_req_valid = r_req_valid;
    assign o_req_data  = r_req_data;
    assign o_req_way   = r_req_way;

endmodule

// File: tb/tb_nfc_req_queue.sv
// Bench for nfc_req_queue: directed scenarios plus randomized traffic, checked by a
// scoreboard fed from a behavioural model of translation, ordering and CIDs.
module tb_nfc_req_queue;
    localparam int NW    = 3;
    localparam int WW    = 2;
    localparam int DEPTH = 4;
    localparam int RW    = 264;
    localparam int QW    = RW + WW;

    logic            clk = 1'b0;
    logic            rst;
    logic            o_ready;
    logic            i_valid;
    logic [15:0]     i_opc;
    logic [47:0]     i_lba;
    logic [23:0]     i_len;
    logic [WW-1:0]   i_way;
    logic            o_err;
    logic [NW-1:0]   o_req_valid;
    logic [NW-1:0]   i_req_ready;
    logic [RW-1:0]   o_req_data;
    logic [WW-1:0]   o_req_way;
    logic [2:0]      o_fifo_cnt;

    logic [QW-1:0]   exp_q[$];
    int              err_q[$];
    logic [15:0]     m_cid [NW];
    int              cyc = 0;
    int              tests = 0;
    int              fails = 0;
    bit              rand_rdy = 1'b0;

    logic [15:0] ops [14] = '{16'h1080, 16'h1085, 16'h3000, 16'h3500, 16'hD060,
                              16'h00FF, 16'h01EF, 16'h02EF, 16'h00EC, 16'h01EE,
                              16'h2090, 16'h0090, 16'h00ED, 16'h1234};

    nfc_req_queue #(
        .WAY_NUM    (NW),
        .WAY_W      (WW),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .o_ready     (o_ready),
        .i_valid     (i_valid),
        .i_opc       (i_opc),
        .i_lba       (i_lba),
        .i_len       (i_len),
        .i_way       (i_way),
        .o_err       (o_err),
        .o_req_valid (o_req_valid),
        .i_req_ready (i_req_ready),
        .o_req_data  (o_req_data),
        .o_req_way   (o_req_way),
        .o_fifo_cnt  (o_fifo_cnt)
    );

    // ---------------- clock / reset
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    // ---------------- checking helpers and reference model
    task automatic chk(input string name, input logic [RW-1:0] act, input logic [RW-1:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [RW-1:0] ref_entry(input logic [15:0] opc, input logic [47:0] lba,
                                                input logic [23:0] len, output bit ok);
        logic [15:0] o;
        logic [47:0] a;
        logic [23:0] l;
        logic [63:0] x;
        ok = 1'b1; o = opc; a = '0; l = '0; x = '0;
        case (opc)
            16'h1080, 16'h1085, 16'h3000, 16'h3500, 16'hD060: begin a = lba; l = len; end
            16'h00FF, 16'h0090, 16'h00ED: ;
            16'h01EF: begin o = 16'h00EF; a = 48'd1; x = 64'h24; end
            16'h02EF: begin o = 16'h00EF; a = 48'd2; x = 64'h7; end
            16'h00EC: l = 24'h100;
            16'h01EE: begin o = 16'h00EE; a = 48'd1; l = 24'h100; end
            16'h2090: begin o = 16'h0090; a = 48'h20; end
            default:  ok = 1'b0;
        endcase
        return {96'h0, x, l, a, 16'h0, o};
    endfunction

    // ---------------- driver tasks (called at posedge + #1)
    task automatic tick(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic send(input logic [15:0] opc, input logic [47:0] lba,
                        input logic [23:0] len, input logic [WW-1:0] way);
        int          guard;
        bit          ok;
        logic [RW-1:0] e;
        guard = 0;
        while (!o_ready && guard < 500) begin tick(1); guard++; end
        if (!o_ready) begin
            chk("send_timeout", 0, 1);
        end else begin
            i_valid = 1'b1; i_opc = opc; i_lba = lba; i_len = len; i_way = way;
            e = ref_entry(opc, lba, len, ok);
            if (ok && int'(way) < NW) exp_q.push_back({way, e});
            else err_q.push_back(cyc + 1);
            tick(1);
            i_valid = 1'b0;
        end
    endtask

    task automatic wait_drain();
        int guard;
        guard = 0;
        while ((exp_q.size() != 0 || err_q.size() != 0) && guard < 2000) begin tick(1); guard++; end
        chk("drain_left", exp_q.size() + err_q.size(), 0);
        tick(2);
    endtask

    task automatic reset_model();
        exp_q.delete();
        err_q.delete();
        for (int w = 0; w < NW; w++) m_cid[w] = '0;
    endtask

    always @(posedge clk) begin
        #1;
        if (rand_rdy) i_req_ready = NW'($urandom_range(0, 7));
    end

    // ---------------- monitor / scoreboard
    bit            prev_stall = 1'b0;
    logic [RW-1:0] prev_data;
    logic [WW-1:0] prev_way;

    always @(negedge clk) begin
        logic [QW-1:0]  e;
        logic [RW-1:0]  ed;
        logic [WW-1:0]  ew;
        logic [NW-1:0]  oh;
        if (rst) begin
            prev_stall = 1'b0;
        end else begin
            if (o_err) begin
                if (err_q.size() == 0) chk("err_unexpected", 1, 0);
                else chk("err_cycle", cyc, err_q.pop_front());
            end
            if (prev_stall) begin
                chk("hold_data", o_req_data, prev_data);
                chk("hold_way", o_req_way, prev_way);
            end
            if (o_req_valid != '0) begin
                oh = NW'(1) << o_req_way;
                chk("valid_onehot", o_req_valid, oh);
                if ((o_req_valid & i_req_ready) != '0) begin
                    if (exp_q.size() == 0) begin
                        chk("req_unexpected", 1, 0);
                    end else begin
                        e  = exp_q.pop_front();
                        ew = e[QW-1 -: WW];
                        ed = e[RW-1:0];
                        ed[31:16] = m_cid[ew];
                        m_cid[ew] = m_cid[ew] + 16'd1;
                        chk("req_data", o_req_data, ed);
                        chk("req_way", o_req_way, ew);
                    end
                end
            end
            prev_stall = (o_req_valid != '0) && ((o_req_valid & i_req_ready) == '0);
            prev_data  = o_req_data;
            prev_way   = o_req_way;
        end
    end

    // ---------------- stimulus
    initial begin
        logic [47:0] lba;
        logic [15:0] opc;
        int          idx;
        rst = 1'b1; i_valid = 1'b0; i_opc = '0; i_lba = '0; i_len = '0; i_way = '0;
        i_req_ready = '0;
        reset_model();
        tick(3);
        chk("rst_valid", o_req_valid, 0);
        chk("rst_data", o_req_data, 0);
        chk("rst_way", o_req_way, 0);
        chk("rst_err", o_err, 0);
        chk("rst_cnt", o_fifo_cnt, 0);
        chk("rst_ready", o_ready, 1);
        rst = 1'b0;
        tick(1);

        // Latency of a single read command.
        i_req_ready = '1;
        send(16'h3000, 48'h123456, 24'h4000, 2'd0);
        chk("lat_not_yet", o_req_valid, 0);
        chk("lat_fifo_cnt", o_fifo_cnt, 1);
        tick(1);
        chk("lat_valid", o_req_valid, 3'b001);
        chk("lat_data", o_req_data[103:0], {24'h004000, 48'h000000123456, 16'h0000, 16'h3000});
        wait_drain();
        send(16'h3000, 48'h1, 24'h10, 2'd0);
        send(16'h02EF, 48'hABC, 24'h55, 2'd1);
        send(16'h01EE, 48'hDEF, 24'h66, 2'd2);
        wait_drain();

        // Rejections: unsupported opcode and out-of-range way.
        send(16'h1234, 48'h0, 24'h0, 2'd0);
        send(16'h3000, 48'h0, 24'h0, 2'(NW));
        tick(3);
        chk("rej_err_seen", err_q.size(), 0);
        chk("rej_cnt", o_fifo_cnt, 0);
        chk("rej_valid", o_req_valid, 0);

        // Head-of-line stall, FIFO full, then release.
        i_req_ready = '0;
        send(16'h3000, 48'h10, 24'h1, 2'd0);
        send(16'h3500, 48'h11, 24'h2, 2'd1);
        send(16'h1080, 48'h12, 24'h3, 2'd0);
        tick(3);
        chk("stall_valid", o_req_valid, 3'b001);
        chk("stall_cnt", o_fifo_cnt, 2);
        i_req_ready = 3'b110;
        send(16'h00EC, 48'h13, 24'h4, 2'd2);
        send(16'h2090, 48'h14, 24'h5, 2'd1);
        chk("full_ready", o_ready, 0);
        chk("full_cnt", o_fifo_cnt, DEPTH);
        chk("stall_valid2", o_req_valid, 3'b001);
        i_req_ready = '1;
        wait_drain();

        // Randomized traffic with random per-way ready.
        rand_rdy = 1'b1;
        for (int n = 0; n < 400; n++) begin
            idx = $urandom_range(0, 15);
            opc = (idx < 14) ? ops[idx] : 16'($urandom);
            lba = 48'({$urandom, $urandom});
            send(opc, lba, 24'($urandom), 2'($urandom_range(0, 3)));
        end
        rand_rdy = 1'b0;
        tick(1);
        i_req_ready = '1;
        wait_drain();

        // Reset with one request in flight and three queued.
        i_req_ready = '0;
        for (int n = 0; n < 4; n++) send(16'h3000, 48'(n), 24'h8, 2'(n % NW));
        tick(1);
        chk("pre_rst_cnt", o_fifo_cnt, 3);
        chk("pre_rst_valid", o_req_valid, 3'b001);
        rst = 1'b1;
        tick(1);
        reset_model();
        chk("mid_rst_valid", o_req_valid, 0);
        chk("mid_rst_data", o_req_data, 0);
        chk("mid_rst_way", o_req_way, 0);
        chk("mid_rst_err", o_err, 0);
        chk("mid_rst_cnt", o_fifo_cnt, 0);
        chk("mid_rst_ready", o_ready, 1);
        rst = 1'b0;
        tick(1);

        // CID wrap on way 0 after 65536 handshakes.
        i_req_ready = '1;
        for (int n = 0; n < 65536; n++) send(16'hD060, 48'(n), 24'h200, 2'd0);
        wait_drain();
        i_req_ready = '0;
        send(16'h1085, 48'h77, 24'h9, 2'd0);
        tick(1);
        chk("wrap_cid", o_req_data[31:16], 16'h0000);
        i_req_ready = '1;
        wait_drain();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
